// File: rtl/frac_accum_reduce_ctrl.sv
// Accumulates numerators over 2^FRAC_BITS, splits into integer part and remainder,
// then reduces the remainder to lowest terms. Optional macro FRAC_SAT_EN saturates on overflow.
module frac_accum_reduce_ctrl #(
    parameter int FRAC_BITS = 4,
    parameter int IN_W      = 5,
    parameter int ACC_W     = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [IN_W-1:0]          in_num,
    input  logic                     in_last,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [ACC_W-FRAC_BITS-1:0] out_int,
    output logic [FRAC_BITS:0]       out_num,
    output logic [FRAC_BITS:0]       out_den,
    output logic                     out_ovf,
    output logic                     busy
);
    localparam int INT_W = ACC_W - FRAC_BITS;
    localparam int NUM_W = FRAC_BITS + 1;

    typedef enum logic [1:0] {
        ST_ACC    = 2'd0,
        ST_REDUCE = 2'd1,
        ST_OUT    = 2'd2
    } state_t;

    state_t             state_r;
    logic [ACC_W-1:0]   acc_r;
    logic               ovf_r;
    logic [INT_W-1:0]   int_r;
    logic [NUM_W-1:0]   num_r;
    logic [NUM_W-1:0]   den_r;
    logic               in_ready_r;
    logic               out_valid_r;
    logic               busy_r;
    logic [INT_W-1:0]   out_int_r;
    logic [NUM_W-1:0]   out_num_r;
    logic [NUM_W-1:0]   out_den_r;
    logic               out_ovf_r;

    logic [ACC_W:0]     sum_s;
    logic [ACC_W-1:0]   acc_next_s;
    logic               take_s;

    // Widened sum; carry bit flags overflow of the accumulator.
    always_comb begin
        sum_s  = {1'b0, acc_r} + {{(ACC_W+1-IN_W){1'b0}}, in_num};
        take_s = in_valid & in_ready_r & (state_r == ST_ACC);
`ifdef FRAC_SAT_EN
        if (sum_s[ACC_W]) begin
            acc_next_s = {ACC_W{1'b1}};
        end else begin
            acc_next_s = sum_s[ACC_W-1:0];
        end
`else
        acc_next_s = sum_s[ACC_W-1:0];
`endif
    end

    // Controller FSM with all outputs registered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_ACC;
            acc_r       <= {ACC_W{1'b0}};
            ovf_r       <= 1'b0;
            int_r       <= {INT_W{1'b0}};
            num_r       <= {NUM_W{1'b0}};
            den_r       <= {NUM_W{1'b0}};
            in_ready_r  <= 1'b0;
            out_valid_r <= 1'b0;
            busy_r      <= 1'b0;
            out_int_r   <= {INT_W{1'b0}};
            out_num_r   <= {NUM_W{1'b0}};
            out_den_r   <= {NUM_W{1'b0}};
            out_ovf_r   <= 1'b0;
        end else begin
            case (state_r)
                ST_ACC: begin
                    in_ready_r <= 1'b1;
                    if (take_s) begin
                        ovf_r <= ovf_r | sum_s[ACC_W];
                        if (in_last) begin
                            int_r      <= acc_next_s[ACC_W-1:FRAC_BITS];
                            num_r      <= {1'b0, acc_next_s[FRAC_BITS-1:0]};
                            den_r      <= {1'b1, {FRAC_BITS{1'b0}}};
                            in_ready_r <= 1'b0;
                            busy_r     <= 1'b1;
                            state_r    <= ST_REDUCE;
                        end else begin
                            acc_r <= acc_next_s;
                        end
                    end
                end
                ST_REDUCE: begin
                    if (num_r == {NUM_W{1'b0}}) begin
                        out_int_r   <= int_r;
                        out_num_r   <= {NUM_W{1'b0}};
                        out_den_r   <= {{FRAC_BITS{1'b0}}, 1'b1};
                        out_ovf_r   <= ovf_r;
                        out_valid_r <= 1'b1;
                        state_r     <= ST_OUT;
                    end else if (!num_r[0]) begin
                        num_r <= num_r >> 1;
                        den_r <= den_r >> 1;
                    end else begin
                        out_int_r   <= int_r;
                        out_num_r   <= num_r;
                        out_den_r   <= den_r;
                        out_ovf_r   <= ovf_r;
                        out_valid_r <= 1'b1;
                        state_r     <= ST_OUT;
                    end
                end
                ST_OUT: begin
                    if (out_ready) begin
                        acc_r       <= {ACC_W{1'b0}};
                        ovf_r       <= 1'b0;
                        out_valid_r <= 1'b0;
                        busy_r      <= 1'b0;
                        in_ready_r  <= 1'b1;
                        state_r     <= ST_ACC;
                    end
                end
                default: begin
                    state_r     <= ST_ACC;
                    in_ready_r  <= 1'b0;
                    out_valid_r <= 1'b0;
                    busy_r      <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign busy      = busy_r;
    assign out_int   = out_int_r;
    assign out_num   = out_num_r;
    assign out_den   = out_den_r;
    assign out_ovf   = out_ovf_r;

endmodule

// File: tb/tb_frac_accum_reduce_ctrl.sv
// Directed bench for frac_accum_reduce_ctrl with hand-computed expected results.
module tb_frac_accum_reduce_ctrl;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [4:0] in_num = 5'd0;
    logic       in_last = 1'b0;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [3:0] out_int;
    logic [4:0] out_num;
    logic [4:0] out_den;
    logic       out_ovf;
    logic       busy;

    int total = 0;
    int bad = 0;

    frac_accum_reduce_ctrl dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_num(in_num), .in_last(in_last),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_int(out_int), .out_num(out_num), .out_den(out_den), .out_ovf(out_ovf),
        .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Present one operand and hold it until accepted; returns #1 after the handshake edge.
    task automatic send(input logic [4:0] n, input logic l);
        int k;
        k = 0;
        in_valid = 1'b1;
        in_num   = n;
        in_last  = l;
        while (!in_ready && k < 50) begin
            @(posedge clk); #1;
            k++;
        end
        chk("in_ready_wait", {31'd0, in_ready}, 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    // Wait for the result, check it and the REDUCE cycle count, then accept it.
    task automatic collect(input string tag, input int ei, input int en, input int ed,
                           input int eo, input int ered);
        int k;
        int g;
        k = 0;
        g = 0;
        while (!out_valid && g < 50) begin
            if (busy) k++;
            @(posedge clk); #1;
            g++;
        end
        chk({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
        chk({tag, "_reduce"}, k, ered);
        chk({tag, "_int"}, {28'd0, out_int}, ei);
        chk({tag, "_num"}, {27'd0, out_num}, en);
        chk({tag, "_den"}, {27'd0, out_den}, ed);
        chk({tag, "_ovf"}, {31'd0, out_ovf}, eo);
        chk({tag, "_rdy_lo"}, {31'd0, in_ready}, 32'd0);
        chk({tag, "_busy"}, {31'd0, busy}, 32'd1);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk({tag, "_valid_drop"}, {31'd0, out_valid}, 32'd0);
        chk({tag, "_busy_drop"}, {31'd0, busy}, 32'd0);
        chk({tag, "_rdy_back"}, {31'd0, in_ready}, 32'd1);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_valid"}, {31'd0, out_valid}, 32'd0);
        chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
        chk({tag, "_rdy"}, {31'd0, in_ready}, 32'd0);
        chk({tag, "_int"}, {28'd0, out_int}, 32'd0);
        chk({tag, "_num"}, {27'd0, out_num}, 32'd0);
        chk({tag, "_den"}, {27'd0, out_den}, 32'd0);
        chk({tag, "_ovf"}, {31'd0, out_ovf}, 32'd0);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk_zero("rst");
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("rst_rdy_rise", {31'd0, in_ready}, 32'd1);

        // 5+7+6 = 18 -> 1 + 2/16 = 1 1/8
        send(5'd5, 1'b0); send(5'd7, 1'b0); send(5'd6, 1'b1);
        collect("g18", 1, 1, 8, 0, 2);
        send(5'd16, 1'b1);
        collect("g16", 1, 0, 1, 0, 1);
        send(5'd8, 1'b1);
        collect("g8", 0, 1, 2, 0, 4);
        send(5'd3, 1'b1);
        collect("g3", 0, 3, 16, 0, 1);
        send(5'd0, 1'b0); send(5'd0, 1'b1);
        collect("g0", 0, 0, 1, 0, 1);

        // 9 x 31 = 279 overflows 8 bits; result held under backpressure
        for (int i = 0; i < 8; i++) send(5'd31, 1'b0);
        send(5'd31, 1'b1);
        for (int i = 0; i < 10 && !out_valid; i++) begin
            @(posedge clk); #1;
        end
        in_valid = 1'b1;
        in_num   = 5'd9;
        in_last  = 1'b1;
        for (int i = 0; i < 5; i++) begin
            chk("bp_valid", {31'd0, out_valid}, 32'd1);
            chk("bp_rdy", {31'd0, in_ready}, 32'd0);
`ifdef FRAC_SAT_EN
            chk("bp_int", {28'd0, out_int}, 32'd15);
            chk("bp_num", {27'd0, out_num}, 32'd15);
`else
            chk("bp_int", {28'd0, out_int}, 32'd1);
            chk("bp_num", {27'd0, out_num}, 32'd7);
`endif
            chk("bp_den", {27'd0, out_den}, 32'd16);
            chk("bp_ovf", {31'd0, out_ovf}, 32'd1);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
`ifdef FRAC_SAT_EN
        collect("gov", 15, 15, 16, 1, 0);
`else
        collect("gov", 1, 7, 16, 1, 0);
`endif
        // acc and ovf must start clean: 6+2 = 8 -> 1/2
        send(5'd6, 1'b0); send(5'd2, 1'b1);
        collect("gclr", 0, 1, 2, 0, 4);

        // reset mid-group
        send(5'd5, 1'b0); send(5'd5, 1'b0);
        rst_n = 1'b0;
        #1;
        chk_zero("rst_mid");
        @(posedge clk); #1;
        rst_n = 1'b1;
        send(5'd4, 1'b1);
        collect("gr1", 0, 1, 4, 0, 3);

        // reset during REDUCE
        send(5'd8, 1'b1);
        @(posedge clk); #1;
        chk("red_busy", {31'd0, busy}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk_zero("rst_red");
        @(posedge clk); #1;
        rst_n = 1'b1;
        send(5'd4, 1'b1);
        collect("gr2", 0, 1, 4, 0, 3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end
endmodule
